dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte write enables; the read data register updates only on a load access.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, fixed access latency, one response per request.
// Optional access-fault checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ready_q;
    logic              err_q;
    logic              accept;
    logic              access;
    logic              fault;

    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              acc_we;
    logic [DATA_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] arr_rdata;

    // Valid/ready: a transfer happens at a rising edge where both are 1; outputs drop while rst_n is low.
    assign req_ready = ready_q && rst_n;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP) && rst_n;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? arr_rdata : '0;

    // With a single-cycle latency the access lands on the accepting edge, so it uses the live request.
    always_comb begin
        if (LATENCY == 1) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    assign fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);
`else
    logic unused_addr_bits;
    assign fault            = 1'b0;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[DATA_W-1:IDX_W+2]};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A reset edge must never commit a pending store.
        if (!rst_n) begin
            state_next = IDLE;
            cnt_next   = '0;
            access     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state <= state_next;
        cnt   <= cnt_next;
        if (!rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= (state_next == IDLE);
            if (access) begin
                err_q <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (access && !fault),
        .we    (acc_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 3 and 1) sharing the request bus.
module tb_dmem_responder;

    int n_vec = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        rst_b = 1'b0;
    logic        go    = 1'b0;
    logic        rr    = 1'b1;
    int          sel   = 0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;

    logic        valid_a, ready_a, rspv_a, err_a;
    logic        valid_b, ready_b, rspv_b, err_b;
    logic        valid_c, ready_c, rspv_c, err_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    assign valid_a = go && (sel == 0);
    assign valid_b = go && (sel == 1);
    assign valid_c = go && (sel == 2);

    always_comb begin
        cur_ready = ready_a;
        cur_valid = rspv_a;
        cur_rdata = rdata_a;
        cur_err   = err_a;
        case (sel)
            1: begin cur_ready = ready_b; cur_valid = rspv_b; cur_rdata = rdata_b; cur_err = err_b; end
            2: begin cur_ready = ready_c; cur_valid = rspv_c; cur_rdata = rdata_c; cur_err = err_c; end
            default: ;
        endcase
    end

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rspv_a), .rsp_ready(rr), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_b), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rspv_b), .rsp_ready(rr), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_c), .req_ready(ready_c),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rspv_c), .rsp_ready(rr), .rsp_rdata(rdata_c), .rsp_err(err_c)
    );

    // Driver: issue one request on the selected instance, return {timeout, latency, rdata, err}.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [41:0] res);
        int   n;
        int   lat;
        logic to;
        to = 1'b0;
        n  = 0;
        while (cur_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (cur_ready !== 1'b1) to = 1'b1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rr = 1'b1;
        go = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        lat = 1;
        while (cur_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        if (cur_valid !== 1'b1) to = 1'b1;
        res = {to, 8'(lat), cur_rdata, cur_err};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_b = 1'b0;
        sel = 0; go = 1'b1; rr = 1'b0;
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", ready_a); end
        n_vec++; if (rspv_a !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rspv_a); end
        n_vec++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rdata_a); end
        n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %b want 0", err_a); end
        n_vec++;
        if ({ready_b, rspv_b, ready_c, rspv_c} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_others: got %b want 0000", {ready_b, rspv_b, ready_c, rspv_c});
        end
        go = 1'b0; rr = 1'b1;
        rst_n = 1'b1; rst_b = 1'b1;
        n_vec++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_ready_registered: got %b want 0", ready_a); end
        @(posedge clk); #1;
        n_vec++; if ({ready_a, rspv_a} !== 2'b10) begin n_bad++; $display("FAIL rst_release: got %b want 10", {ready_a, rspv_a}); end
    endtask

    task automatic test_store_load();
        logic [41:0] res;
        sel = 0;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b0}) begin n_bad++; $display("FAIL store_full: got %h want %h", res, {1'b0, 8'd2, 32'h0, 1'b0}); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'hDEAD_BEEF, 1'b0}) begin n_bad++; $display("FAIL load_full: got %h want %h", res, {1'b0, 8'd2, 32'hDEAD_BEEF, 1'b0}); end
    endtask

    task automatic test_partial();
        logic [41:0] res;
        sel = 0;
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b0}) begin n_bad++; $display("FAIL store_be1: got %h", res); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'hDEAD_BEAA, 1'b0}) begin n_bad++; $display("FAIL load_be1: got %h want rdata deadbeaa", res); end
        do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b0}) begin n_bad++; $display("FAIL store_be0: got %h want response lat 2", res); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'hDEAD_BEAA, 1'b0}) begin n_bad++; $display("FAIL load_be0: got %h want rdata deadbeaa", res); end
        do_req(1'b1, 32'h10, 32'h1122_3344, 4'b1010, res);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h11AD_33AA, 1'b0}) begin n_bad++; $display("FAIL load_be1010: got %h want rdata 11ad33aa", res); end
    endtask

    task automatic test_backpressure();
        logic [41:0] res;
        int          n;
        logic        extra;
        sel = 0;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        rr = 1'b0;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        n = 0;
        while (cur_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({cur_valid, cur_rdata, cur_err, cur_ready} !== {1'b1, 32'h11AD_33AA, 1'b0, 1'b0}) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got v=%b d=%h e=%b r=%b want v=1 d=11ad33aa e=0 r=0",
                                  i, cur_valid, cur_rdata, cur_err, cur_ready);
            end
            if (i == 1) begin
                req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF; go = 1'b1;
            end else begin
                go = 1'b0;
            end
            @(posedge clk); #1;
        end
        go = 1'b0;
        rr = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({cur_valid, cur_ready} !== 2'b01) begin n_bad++; $display("FAIL stall_release: got %b want 01", {cur_valid, cur_ready}); end
        extra = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (cur_valid !== 1'b0) extra = 1'b1; end
        n_vec++; if (extra !== 1'b0) begin n_bad++; $display("FAIL stall_no_extra_rsp: got %b want 0", extra); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h11AD_33AA, 1'b0}) begin n_bad++; $display("FAIL stall_no_write: got %h want rdata 11ad33aa", res); end
    endtask

    task automatic test_reset_mid();
        logic [41:0] res;
        logic        seen;
        sel = 1;
        do_req(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, res);
        n_vec++; if (res !== {1'b0, 8'd3, 32'h0, 1'b0}) begin n_bad++; $display("FAIL l3_store: got %h want lat 3", res); end
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        // Reset is sampled on the edge that would have performed the store.
        rst_b = 1'b0;
        n_vec++; if ({rspv_b, ready_b} !== 2'b00) begin n_bad++; $display("FAIL midrst_assert: got %b want 00", {rspv_b, ready_b}); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (rspv_b !== 1'b0) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp: got %b want 0", seen); end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd3, 32'hA5A5_A5A5, 1'b0}) begin n_bad++; $display("FAIL midrst_not_committed: got %h want rdata a5a5a5a5", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic        we_v[4];
        logic [31:0] addr_v[4];
        logic [31:0] wdata_v[4];
        logic [31:0] exp;
        logic        will;
        int          idx, nacc, nrsp, last_acc;
        we_v[0] = 1'b1; addr_v[0] = 32'h40; wdata_v[0] = 32'h0102_0304;
        we_v[1] = 1'b1; addr_v[1] = 32'h44; wdata_v[1] = 32'h0A0B_0C0D;
        we_v[2] = 1'b0; addr_v[2] = 32'h40; wdata_v[2] = 32'h0;
        we_v[3] = 1'b0; addr_v[3] = 32'h44; wdata_v[3] = 32'h0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0102_0304);
        exp_q.push_back(32'h0A0B_0C0D);
        sel = 2; rr = 1'b1;
        idx = 0; nacc = 0; nrsp = 0; last_acc = -1;
        req_we = we_v[0]; req_addr = addr_v[0]; req_wdata = wdata_v[0]; req_be = 4'hF;
        go = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            will = go && cur_ready;
            @(posedge clk); #1;
            if (will) begin
                if (last_acc >= 0) begin
                    n_vec++; if (cyc - last_acc != 2) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d want 2", cyc - last_acc); end
                end
                last_acc = cyc;
                nacc++;
                idx++;
                if (idx < 4) begin
                    req_we = we_v[idx]; req_addr = addr_v[idx]; req_wdata = wdata_v[idx];
                end else begin
                    go = 1'b0;
                end
            end
            if (cur_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAAD_F00D;
                nrsp++;
                n_vec++;
                // Valid right after the accepting edge means the response handshakes at accept+1.
                if (cur_rdata !== exp || cyc != last_acc) begin
                    n_bad++; $display("FAIL b2b_rsp[%0d]: got d=%h at %0d want d=%h at %0d", nrsp, cur_rdata, cyc, exp, last_acc);
                end
            end
        end
        n_vec++; if (nacc != 4 || nrsp != 4) begin n_bad++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 4/4", nacc, nrsp); end
    endtask

`ifdef DMEM_ERR_CHECK_EN
    task automatic test_err_check();
        logic [41:0] res;
        sel = 0;
        do_req(1'b0, 32'h13, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b1}) begin n_bad++; $display("FAIL err_misaligned_load: got %h want err 1 rdata 0", res); end
        do_req(1'b1, 32'h1000, 32'h0000_0055, 4'hF, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b1}) begin n_bad++; $display("FAIL err_oor_store: got %h want err 1", res); end
        do_req(1'b1, 32'h1010, 32'h0000_0BAD, 4'hF, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b1}) begin n_bad++; $display("FAIL err_oor_store2: got %h want err 1", res); end
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b1}) begin n_bad++; $display("FAIL err_oor_load: got %h want err 1 rdata 0", res); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h11AD_33AA, 1'b0}) begin n_bad++; $display("FAIL err_no_write: got %h want rdata 11ad33aa", res); end
    endtask
`else
    task automatic test_alias();
        logic [41:0] res;
        sel = 0;
        do_req(1'b1, 32'h1010, 32'hCAFE_F00D, 4'hF, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'h0, 1'b0}) begin n_bad++; $display("FAIL alias_store: got %h want err 0", res); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'hCAFE_F00D, 1'b0}) begin n_bad++; $display("FAIL alias_load: got %h want rdata cafef00d", res); end
        do_req(1'b0, 32'h13, 32'h0, 4'h0, res);
        n_vec++; if (res !== {1'b0, 8'd2, 32'hCAFE_F00D, 1'b0}) begin n_bad++; $display("FAIL alias_low_bits: got %h want rdata cafef00d err 0", res); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial();
        test_backpressure();
`ifdef DMEM_ERR_CHECK_EN
        test_err_check();
`else
        test_alias();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
